// File: rtl/multiword_add_sequencer_pkg.sv
// rtl/multiword_add_sequencer_pkg.sv - shared types and state encodings for the multiword add sequencer
// Purpose: FSM state type and its encodings, used by the sequencer top level.
// Ports: none (package).
package add_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } add_seq_state_t;

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// rtl/multiword_add_sequencer_if.sv - operand/result handshake bundle for the multiword add sequencer
// Purpose: groups operand input handshake and result output handshake signals.
// Ports (as signals): in_valid/in_ready/a/b/cin (operand side),
//   out_valid/out_ready/sum/carry (result side), busy, and ovf when
//   ADD_SEQ_SIGNED_OVF_EN is defined.
// Modports: master = operand source + result consumer, slave = sequencer.
interface multiword_add_sequencer_if #(
  parameter int SIZE  = 8,
  parameter int WORDS = 4
);
  localparam int WIDE = SIZE * WORDS;

  logic            in_valid;
  logic            in_ready;
  logic [WIDE-1:0] a;
  logic [WIDE-1:0] b;
  logic            cin;
  logic            out_valid;
  logic            out_ready;
  logic [WIDE-1:0] sum;
  logic            carry;
  logic            busy;
`ifdef ADD_SEQ_SIGNED_OVF_EN
  logic            ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, carry, busy, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, carry, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, carry, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, carry, busy
  );
`endif

endinterface

// File: rtl/multiword_add_sequencer_chunk_adder.sv
// rtl/multiword_add_sequencer_chunk_adder.sv - combinational SIZE-bit adder with carry in/out
// Purpose: {cout,sum} = a + b + cin over SIZE bits.
// Ports: a, b (SIZE) operands; cin carry in; sum (SIZE) result; cout carry out.
module chunk_adder #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic            cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_sequencer.sv
// rtl/multiword_add_sequencer.sv - WIDE-bit adder built from one SIZE-bit chunk adder over WORDS cycles
// Purpose: accepts a,b,cin, adds one SIZE-bit chunk per cycle (carry rippled
//   through a register), then presents {carry,sum} until the consumer accepts.
// Ports: clk, rst_n (async active-low); bus (slave modport) carrying
//   in_valid/in_ready/a/b/cin, out_valid/out_ready/sum/carry, busy.
// Option: ADD_SEQ_SIGNED_OVF_EN adds bus.ovf, two's-complement overflow of the full add.
module multiword_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multiword_add_sequencer_if.slave  bus
);

  localparam int WIDE  = SIZE * WORDS;
  localparam int IDX_W = $clog2(WORDS + 1);

  add_seq_state_t   state;
  add_seq_state_t   state_next;
  logic [WIDE-1:0]  a_sh;
  logic [WIDE-1:0]  b_sh;
  logic [WIDE-1:0]  sum_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx;
  logic [SIZE-1:0]  chunk_sum;
  logic             chunk_carry;
  logic             accept;
  logic             last_chunk;
`ifdef ADD_SEQ_SIGNED_OVF_EN
  logic             ovf_r;
`endif

  chunk_adder #(.SIZE(SIZE)) u_chunk_adder (
    .a    (a_sh[SIZE-1:0]),
    .b    (b_sh[SIZE-1:0]),
    .cin  (carry_r),
    .sum  (chunk_sum),
    .cout (chunk_carry)
  );

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last_chunk = (idx == IDX_W'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     if (last_chunk)   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands drain from the low end while each chunk result enters sum from
  // the top, so after WORDS shifts chunk 0 sits at the bottom of sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
`ifdef ADD_SEQ_SIGNED_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh    <= bus.a;
      b_sh    <= bus.b;
      carry_r <= bus.cin;
      idx     <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> SIZE;
      b_sh    <= b_sh >> SIZE;
      sum_r   <= (sum_r >> SIZE) | (WIDE'(chunk_sum) << (WIDE - SIZE));
      carry_r <= chunk_carry;
      idx     <= last_chunk ? idx : idx + IDX_W'(1);
`ifdef ADD_SEQ_SIGNED_OVF_EN
      // In the last chunk the low bits of the shift regs hold the operand MSBs.
      if (last_chunk) begin
        ovf_r <= (a_sh[SIZE-1] == b_sh[SIZE-1]) && (chunk_sum[SIZE-1] != a_sh[SIZE-1]);
      end
`endif
    end
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
    bus.sum       = sum_r;
    bus.carry     = carry_r;
`ifdef ADD_SEQ_SIGNED_OVF_EN
    bus.ovf       = ovf_r;
`endif
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb/tb_multiword_add_sequencer.sv - self-checking bench for multiword_add_sequencer
module tb_multiword_add_sequencer;

  localparam int SIZE  = 8;
  localparam int WORDS = 4;
  localparam int WIDE  = SIZE * WORDS;

  typedef struct packed {
    logic [WIDE-1:0] sum;
    logic            carry;
    logic            ovf;
  } exp_t;

  typedef struct {
    logic [WIDE-1:0] a;
    logic [WIDE-1:0] b;
    logic            cin;
    exp_t            e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  exp_t sb[$];
  vec_t tbl[8];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiword_add_sequencer_if #(.SIZE(SIZE), .WORDS(WORDS)) bus ();
  multiword_add_sequencer_if #(.SIZE(8), .WORDS(1)) bus1 ();

  multiword_add_sequencer #(.SIZE(SIZE), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  multiword_add_sequencer #(.SIZE(8), .WORDS(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  function automatic exp_t model(input logic [WIDE-1:0] a, input logic [WIDE-1:0] b, input logic cin);
    logic [WIDE:0] s;
    exp_t e;
    s = {1'b0, a} + {1'b0, b} + (WIDE+1)'(cin);
    e.sum   = s[WIDE-1:0];
    e.carry = s[WIDE];
    e.ovf   = (a[WIDE-1] == b[WIDE-1]) && (s[WIDE-1] != a[WIDE-1]);
    return e;
  endfunction

  // Consumer: out_ready policy changes one cycle at a time, away from the edge.
  initial forever begin
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
    @(posedge clk);
    #1;
  end

  // Monitor: latency, hold-stability and scoreboard pops for the WORDS=4 DUT.
  initial begin : mon
    int   acc_cyc;
    bit   has_acc;
    bit   prev_valid;
    bit   prev_hs;
    logic [WIDE-1:0] prev_sum;
    logic prev_carry;
    exp_t e;
    has_acc = 0;
    prev_valid = 0;
    prev_hs = 0;
    acc_cyc = 0;
    prev_sum = '0;
    prev_carry = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        has_acc = 0;
        prev_valid = 0;
        prev_hs = 0;
      end else begin
        if (bus.out_valid && !prev_valid) begin
          if (!has_acc) fail_note("out_valid_without_accept");
          else check("latency", 64'(cyc - acc_cyc), 64'(WORDS));
          has_acc = 0;
        end
        if (bus.out_valid && prev_valid && !prev_hs) begin
          check("hold_sum", 64'(bus.sum), 64'(prev_sum));
          check("hold_carry", 64'(bus.carry), 64'(prev_carry));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            fail_note("unexpected_result");
          end else begin
            e = sb.pop_front();
            check("sum", 64'(bus.sum), 64'(e.sum));
            check("carry", 64'(bus.carry), 64'(e.carry));
`ifdef ADD_SEQ_SIGNED_OVF_EN
            check("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          has_acc = 1;
          acc_cyc = cyc + 1;
        end
        prev_valid = bus.out_valid;
        prev_hs    = bus.out_valid && bus.out_ready;
        prev_sum   = bus.sum;
        prev_carry = bus.carry;
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [WIDE-1:0] a, input logic [WIDE-1:0] b, input logic cin, input exp_t e);
    bit ok;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        sb.push_back(e);
      end
    end
    if (!ok) fail_note("accept_timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.in_ready) ok = 1;
    end
    if (!ok) fail_note("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit   ok;
    logic [WIDE-1:0] ra;
    logic [WIDE-1:0] rb;
    logic rc;

    tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, '{32'h0000_0100, 1'b0, 1'b0}};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, '{32'h0000_0000, 1'b1, 1'b0}};
    tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, '{32'h0000_0000, 1'b1, 1'b1}};
    tbl[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, '{32'hACF1_3569, 1'b0, 1'b0}};
    tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{32'hFFFF_FFFF, 1'b1, 1'b0}};
    tbl[6] = '{32'h00FF_00FF, 32'h00FF_00FF, 1'b0, '{32'h01FE_01FE, 1'b0, 1'b0}};
    tbl[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, '{32'h0000_0000, 1'b0, 1'b0}};

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.a = '0;
    bus1.b = '0;
    bus1.cin = 1'b0;
    bus1.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_carry", 64'(bus.carry), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
`ifdef ADD_SEQ_SIGNED_OVF_EN
    check("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset two cycles into RUN aborts the operation.
    send(tbl[4].a, tbl[4].b, tbl[4].cin, tbl[4].e);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("midrun_busy_before_reset", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrun_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrun_sum", 64'(bus.sum), 64'd0);
    check("midrun_busy", 64'(bus.busy), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (WORDS + 4) begin
      @(negedge clk);
      check("no_result_after_reset", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Table vectors with an always-ready consumer.
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].e);
    end
    drain();

    // Held result: consumer stalls while new operands wait on in_valid.
    rdy_mode = 2;
    send(32'h1111_1111, 32'h2222_2222, 1'b1, '{32'h3333_3334, 1'b0, 1'b0});
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'h2152_4111;
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1;
    end
    if (!ok) fail_note("stall_out_valid_timeout");
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_sum", 64'(bus.sum), 64'h3333_3334);
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        check("accept_in_idle", 64'(bus.busy), 64'd0);
        sb.push_back('{32'h0000_0000, 1'b1, 1'b0});
      end
    end
    if (!ok) fail_note("stall_release_timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();

    // Random operands with random consumer stalls.
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, model(ra, rb, rc));
    end
    drain();
    rdy_mode = 0;

    // WORDS=1 instance: a single RUN cycle.
    bus1.a = 8'hF0;
    bus1.b = 8'h20;
    bus1.cin = 1'b1;
    bus1.in_valid = 1'b1;
    @(negedge clk);
    check("w1_in_ready", 64'(bus1.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("w1_run_out_valid", 64'(bus1.out_valid), 64'd0);
    check("w1_run_busy", 64'(bus1.busy), 64'd1);
    @(negedge clk);
    check("w1_out_valid", 64'(bus1.out_valid), 64'd1);
    check("w1_sum", 64'(bus1.sum), 64'h11);
    check("w1_carry", 64'(bus1.carry), 64'd1);
`ifdef ADD_SEQ_SIGNED_OVF_EN
    check("w1_ovf", 64'(bus1.ovf), 64'd0);
`endif
    @(negedge clk);
    check("w1_back_idle", 64'(bus1.in_ready), 64'd1);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
